ps2_scancode_rom: RTL and testbench
===================================

# ps2_scancode_rom

Synchronous lookup ROM that converts a PS/2 Set‑2 make code into an 8‑bit character code. It selects one of four 256‑entry banks using a language flag and an effective‑shift flag. It sits behind the keyboard front end, which forms the 10‑bit address as {language, shift, scancode} and handles caps‑lock/shift tracking. The output drives the text/display path.

## Interface
- No parameters; all table contents are fixed constants.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active‑high reset.
- addr  input  10  {lang[9], shift[8], scancode[7:0]}; lang 0 = English (ASCII), lang 1 = Thai (TIS‑620); shift = effective shift (shift XOR caps‑lock, computed upstream).
- data  output  8  registered character code; 0x00 = no character.

## Operation
- Bank select: addr[9:8] = 00 English lower, 01 English upper, 10 Thai Kedmanee lower, 11 Thai Kedmanee upper.
- Every address not listed below returns 0x00, including all break/extended codes such as 0xF0 and 0xE0.
- Control keys, identical in all four banks:
  - 0x29 → 0x20 (space)
  - 0x5A → 0x0D (enter)
  - 0x66 → 0x08 (backspace)
- English letters, bank 00 lower / bank 01 upper (0x61–0x7A / 0x41–0x5A):
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m
  - 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
- English digits, bank 00 → '0'–'9', bank 01 → shifted symbol:
  - 45 0/), 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%, 36 6/^, 3D 7/&, 3E 8/*, 46 9/(
  - Caps‑lock therefore also shifts digits; this is intended.
- English punctuation, lower/upper:
  - 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?
  - 0E `/~ returns 0x00 in every bank, because that key toggles the language upstream.
- Thai banks use the standard Kedmanee layout encoded in TIS‑620, for the same 47 keys. Normative anchors:
  - bank 10: 15→0xE6 ๆ, 1D→0xE4 ไ, 24→0xD3 ำ, 2D→0xBE พ, 2C→0xD0 ะ, 1C→0xBF ฟ, 1B→0xCB ห, 23→0xA1 ก, 2B→0xB4 ด, 34→0xE0 เ
  - bank 11: 15→0xF0 ๐, 1C→0xC4 ฤ, 23→0xAF ฏ
  - Kedmanee positions with no TIS‑620 character return 0x00.
- No read enable; the ROM reads every cycle.

## Timing
- Latency is one cycle. addr sampled at edge N appears on data after edge N and stays stable until edge N+1.
- Reset: data = 0x00 after the first edge with reset=1; it holds 0x00 while reset is high. Reset overrides the lookup.
- First valid lookup is at the edge after reset deasserts.
- The output fully tracks addr. A change of bank bits alone, with the same scancode, changes data one cycle later.
- There are no other state elements, so reset mid‑stream has no side effects.

## Structure
- Shared package holds:
  - scancode constants (KEY_A … KEY_SPACE, KEY_ENTER, KEY_BKSP, KEY_GRAVE, KEY_CAPS 0x58, KEY_LSHIFT 0x12, KEY_RSHIFT 0x59)
  - bank‑select constants (BANK_EN_LO/HI, BANK_TH_LO/HI)
  - CHAR_NONE = 0x00
- Implementation: one combinational case on the full 10‑bit address (or four per‑bank case blocks) feeding a single output register.
- One natural sub‑module, ps2_thai_kedmanee_lut, holding the two Thai banks. It is combinational: 9‑bit {shift, scancode} in, 8‑bit code out.

## Test plan
- Reset: reset=1 with addr=0x01C → data=0x00. After release, the next edge → data=0x61.
- English case: addr 0x01C → 0x61; 0x11C → 0x41; 0x016 → 0x31; 0x116 → 0x21; 0x14A → 0x3F.
- Thai: addr 0x223 → 0xA1; 0x323 → 0xAF; 0x215 → 0xE6; 0x315 → 0xF0.
- Common keys in all four banks: scancode 0x29 → 0x20, 0x5A → 0x0D, 0x66 → 0x08.
- Unmapped: scancodes 0xF0, 0xE0, 0x0E, 0x58, 0x12 in every bank → 0x00.
- Latency and back‑to‑back: change addr every cycle through 0x01C, 0x032, 0x021. data follows one cycle late (0x61, 0x62, 0x63) with no bubbles.

Source files
------------

// File: rtl/ps2_scancode_rom_pkg.sv
// rtl/ps2_scancode_rom_pkg.sv - shared scancode, bank and character constants
package ps2_scancode_rom_pkg;

    localparam logic [7:0] KEY_A = 8'h1C, KEY_B = 8'h32, KEY_C = 8'h21, KEY_D = 8'h23,
                           KEY_E = 8'h24, KEY_F = 8'h2B, KEY_G = 8'h34, KEY_H = 8'h33,
                           KEY_I = 8'h43, KEY_J = 8'h3B, KEY_K = 8'h42, KEY_L = 8'h4B,
                           KEY_M = 8'h3A, KEY_N = 8'h31, KEY_O = 8'h44, KEY_P = 8'h4D,
                           KEY_Q = 8'h15, KEY_R = 8'h2D, KEY_S = 8'h1B, KEY_T = 8'h2C,
                           KEY_U = 8'h3C, KEY_V = 8'h2A, KEY_W = 8'h1D, KEY_X = 8'h22,
                           KEY_Y = 8'h35, KEY_Z = 8'h1A;
    localparam logic [7:0] KEY_0 = 8'h45, KEY_1 = 8'h16, KEY_2 = 8'h1E, KEY_3 = 8'h26,
                           KEY_4 = 8'h25, KEY_5 = 8'h2E, KEY_6 = 8'h36, KEY_7 = 8'h3D,
                           KEY_8 = 8'h3E, KEY_9 = 8'h46;
    localparam logic [7:0] KEY_MINUS = 8'h4E, KEY_EQUAL = 8'h55, KEY_LBRACKET = 8'h54,
                           KEY_RBRACKET = 8'h5B, KEY_BSLASH = 8'h5D, KEY_SEMI = 8'h4C,
                           KEY_QUOTE = 8'h52, KEY_COMMA = 8'h41, KEY_PERIOD = 8'h49,
                           KEY_SLASH = 8'h4A, KEY_GRAVE = 8'h0E;
    localparam logic [7:0] KEY_SPACE = 8'h29, KEY_ENTER = 8'h5A, KEY_BKSP = 8'h66,
                           KEY_CAPS = 8'h58, KEY_LSHIFT = 8'h12, KEY_RSHIFT = 8'h59;

    localparam logic [1:0] BANK_EN_LO = 2'b00, BANK_EN_HI = 2'b01,
                           BANK_TH_LO = 2'b10, BANK_TH_HI = 2'b11;

    localparam logic [7:0] CHAR_NONE = 8'h00;

    function automatic logic [7:0] pick(input logic sh, input logic [7:0] lo, input logic [7:0] hi);
        return sh ? hi : lo;
    endfunction

endpackage

// File: rtl/ps2_scancode_rom_thai_kedmanee_lut.sv
// rtl/ps2_scancode_rom_thai_kedmanee_lut.sv - combinational Kedmanee layout to TIS-620
module ps2_thai_kedmanee_lut
    import ps2_scancode_rom_pkg::*;
(
    input  logic [8:0] key_i,
    output logic [7:0] code_o
);

    logic       sh;
    logic [7:0] sc;

    assign sh = key_i[8];
    assign sc = key_i[7:0];

    // Non-Thai glyphs on Kedmanee keys live in the ASCII half of TIS-620.
    always_comb begin
        code_o = CHAR_NONE;
        case (sc)
            KEY_1:        code_o = pick(sh, 8'hE5, 8'h2B);
            KEY_2:        code_o = pick(sh, 8'h2F, 8'hF1);
            KEY_3:        code_o = pick(sh, 8'h2D, 8'hF2);
            KEY_4:        code_o = pick(sh, 8'hC0, 8'hF3);
            KEY_5:        code_o = pick(sh, 8'hB6, 8'hF4);
            KEY_6:        code_o = pick(sh, 8'hD8, 8'hD9);
            KEY_7:        code_o = pick(sh, 8'hD6, 8'hDF);
            KEY_8:        code_o = pick(sh, 8'hA4, 8'hF5);
            KEY_9:        code_o = pick(sh, 8'hB5, 8'hF6);
            KEY_0:        code_o = pick(sh, 8'hA8, 8'hF7);
            KEY_MINUS:    code_o = pick(sh, 8'hA2, 8'hF8);
            KEY_EQUAL:    code_o = pick(sh, 8'hAA, 8'hF9);
            KEY_Q:        code_o = pick(sh, 8'hE6, 8'hF0);
            KEY_W:        code_o = pick(sh, 8'hE4, 8'h22);
            KEY_E:        code_o = pick(sh, 8'hD3, 8'hAE);
            KEY_R:        code_o = pick(sh, 8'hBE, 8'hB1);
            KEY_T:        code_o = pick(sh, 8'hD0, 8'hB8);
            KEY_Y:        code_o = pick(sh, 8'hD1, 8'hED);
            KEY_U:        code_o = pick(sh, 8'hD5, 8'hEA);
            KEY_I:        code_o = pick(sh, 8'hC3, 8'hB3);
            KEY_O:        code_o = pick(sh, 8'hB9, 8'hCF);
            KEY_P:        code_o = pick(sh, 8'hC2, 8'hAD);
            KEY_LBRACKET: code_o = pick(sh, 8'hBA, 8'hB0);
            KEY_RBRACKET: code_o = pick(sh, 8'hC5, 8'h2C);
            KEY_BSLASH:   code_o = pick(sh, 8'hA3, 8'hA5);
            KEY_A:        code_o = pick(sh, 8'hBF, 8'hC4);
            KEY_S:        code_o = pick(sh, 8'hCB, 8'hA6);
            KEY_D:        code_o = pick(sh, 8'hA1, 8'hAF);
            KEY_F:        code_o = pick(sh, 8'hB4, 8'hE2);
            KEY_G:        code_o = pick(sh, 8'hE0, 8'hAC);
            KEY_H:        code_o = pick(sh, 8'hE9, 8'hE7);
            KEY_J:        code_o = pick(sh, 8'hE8, 8'hEB);
            KEY_K:        code_o = pick(sh, 8'hD2, 8'hC9);
            KEY_L:        code_o = pick(sh, 8'hCA, 8'hC8);
            KEY_SEMI:     code_o = pick(sh, 8'hC7, 8'hAB);
            KEY_QUOTE:    code_o = pick(sh, 8'hA7, 8'h2E);
            KEY_Z:        code_o = pick(sh, 8'hBC, 8'h28);
            KEY_X:        code_o = pick(sh, 8'hBB, 8'h29);
            KEY_C:        code_o = pick(sh, 8'hE1, 8'hA9);
            KEY_V:        code_o = pick(sh, 8'hCD, 8'hCE);
            KEY_B:        code_o = pick(sh, 8'hD4, 8'hDA);
            KEY_N:        code_o = pick(sh, 8'hD7, 8'hEC);
            KEY_M:        code_o = pick(sh, 8'hB7, 8'h3F);
            KEY_COMMA:    code_o = pick(sh, 8'hC1, 8'hB2);
            KEY_PERIOD:   code_o = pick(sh, 8'hE3, 8'hCC);
            KEY_SLASH:    code_o = pick(sh, 8'hBD, 8'hC6);
            default:      code_o = CHAR_NONE;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_rom.sv
// rtl/ps2_scancode_rom.sv - registered scancode to character ROM, English and Thai banks
module ps2_scancode_rom
    import ps2_scancode_rom_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] addr,
    output logic [7:0] data
);

    logic       sh;
    logic [7:0] sc;
    logic [7:0] en_code;
    logic [7:0] th_code;
    logic [7:0] data_d;
    logic [7:0] data_q;

    assign sh = addr[8];
    assign sc = addr[7:0];

    ps2_thai_kedmanee_lut u_thai (
        .key_i  (addr[8:0]),
        .code_o (th_code)
    );

    always_comb begin
        en_code = CHAR_NONE;
        case (sc)
            KEY_A: en_code = pick(sh, "a", "A");  KEY_B: en_code = pick(sh, "b", "B");
            KEY_C: en_code = pick(sh, "c", "C");  KEY_D: en_code = pick(sh, "d", "D");
            KEY_E: en_code = pick(sh, "e", "E");  KEY_F: en_code = pick(sh, "f", "F");
            KEY_G: en_code = pick(sh, "g", "G");  KEY_H: en_code = pick(sh, "h", "H");
            KEY_I: en_code = pick(sh, "i", "I");  KEY_J: en_code = pick(sh, "j", "J");
            KEY_K: en_code = pick(sh, "k", "K");  KEY_L: en_code = pick(sh, "l", "L");
            KEY_M: en_code = pick(sh, "m", "M");  KEY_N: en_code = pick(sh, "n", "N");
            KEY_O: en_code = pick(sh, "o", "O");  KEY_P: en_code = pick(sh, "p", "P");
            KEY_Q: en_code = pick(sh, "q", "Q");  KEY_R: en_code = pick(sh, "r", "R");
            KEY_S: en_code = pick(sh, "s", "S");  KEY_T: en_code = pick(sh, "t", "T");
            KEY_U: en_code = pick(sh, "u", "U");  KEY_V: en_code = pick(sh, "v", "V");
            KEY_W: en_code = pick(sh, "w", "W");  KEY_X: en_code = pick(sh, "x", "X");
            KEY_Y: en_code = pick(sh, "y", "Y");  KEY_Z: en_code = pick(sh, "z", "Z");
            // Shift here is already XORed with caps-lock, so digits shift under caps too.
            KEY_0: en_code = pick(sh, "0", ")");  KEY_1: en_code = pick(sh, "1", "!");
            KEY_2: en_code = pick(sh, "2", "@");  KEY_3: en_code = pick(sh, "3", "#");
            KEY_4: en_code = pick(sh, "4", "$");  KEY_5: en_code = pick(sh, "5", "%");
            KEY_6: en_code = pick(sh, "6", "^");  KEY_7: en_code = pick(sh, "7", "&");
            KEY_8: en_code = pick(sh, "8", "*");  KEY_9: en_code = pick(sh, "9", "(");
            KEY_MINUS:    en_code = pick(sh, "-", "_");
            KEY_EQUAL:    en_code = pick(sh, "=", "+");
            KEY_LBRACKET: en_code = pick(sh, "[", "{");
            KEY_RBRACKET: en_code = pick(sh, "]", "}");
            KEY_BSLASH:   en_code = pick(sh, "\\", "|");
            KEY_SEMI:     en_code = pick(sh, ";", ":");
            KEY_QUOTE:    en_code = pick(sh, "'", "\"");
            KEY_COMMA:    en_code = pick(sh, ",", "<");
            KEY_PERIOD:   en_code = pick(sh, ".", ">");
            KEY_SLASH:    en_code = pick(sh, "/", "?");
            default:      en_code = CHAR_NONE;
        endcase
    end

    always_comb begin
        data_d = CHAR_NONE;
        case (sc)
            KEY_SPACE: data_d = 8'h20;
            KEY_ENTER: data_d = 8'h0D;
            KEY_BKSP:  data_d = 8'h08;
            default: begin
                case (addr[9:8])
                    BANK_EN_LO, BANK_EN_HI: data_d = en_code;
                    BANK_TH_LO, BANK_TH_HI: data_d = th_code;
                    default:                data_d = CHAR_NONE;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= CHAR_NONE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_ps2_scancode_rom.sv
// tb/tb_ps2_scancode_rom.sv - directed vector bench for ps2_scancode_rom
module tb_ps2_scancode_rom;

    logic       clk;
    logic       reset;
    logic [9:0] addr;
    logic [7:0] data;

    int n_pass;
    int n_total;

    typedef struct {
        logic [9:0] a;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    ps2_scancode_rom dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] exp);
        n_total++;
        if (data === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: data=0x%02h expected=0x%02h", name, data, exp);
        end
    endtask

    task automatic apply(input logic [9:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        addr = a;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    function automatic vec_t mk(input logic [9:0] a, input logic [7:0] exp, input string name);
        vec_t v;
        v.a = a;
        v.exp = exp;
        v.name = name;
        return v;
    endfunction

    initial begin
        logic [7:0] unmapped[5];
        logic [7:0] common_sc[3];
        logic [7:0] common_ch[3];

        n_pass  = 0;
        n_total = 0;
        unmapped  = '{8'hF0, 8'hE0, 8'h0E, 8'h58, 8'h12};
        common_sc = '{8'h29, 8'h5A, 8'h66};
        common_ch = '{8'h20, 8'h0D, 8'h08};

        vecs.push_back(mk(10'h01C, 8'h61, "en_a"));
        vecs.push_back(mk(10'h11C, 8'h41, "en_A_bank_only"));
        vecs.push_back(mk(10'h016, 8'h31, "en_1"));
        vecs.push_back(mk(10'h116, 8'h21, "en_bang"));
        vecs.push_back(mk(10'h14A, 8'h3F, "en_qmark"));
        vecs.push_back(mk(10'h045, 8'h30, "en_0"));
        vecs.push_back(mk(10'h145, 8'h29, "en_rparen"));
        vecs.push_back(mk(10'h05D, 8'h5C, "en_bslash"));
        vecs.push_back(mk(10'h152, 8'h22, "en_dquote"));
        vecs.push_back(mk(10'h11A, 8'h5A, "en_Z"));
        vecs.push_back(mk(10'h223, 8'hA1, "th_ko_kai"));
        vecs.push_back(mk(10'h323, 8'hAF, "th_to_patak"));
        vecs.push_back(mk(10'h215, 8'hE6, "th_mai_yamok"));
        vecs.push_back(mk(10'h315, 8'hF0, "th_digit0"));
        vecs.push_back(mk(10'h21C, 8'hBF, "th_fo_fan"));
        vecs.push_back(mk(10'h31C, 8'hC4, "th_ru"));
        vecs.push_back(mk(10'h234, 8'hE0, "th_sara_e"));
        vecs.push_back(mk(10'h22D, 8'hBE, "th_pho_phan"));
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++)
                vecs.push_back(mk({b[1:0], common_sc[k]}, common_ch[k], $sformatf("common_b%0d_%02h", b, common_sc[k])));
            for (int k = 0; k < 5; k++)
                vecs.push_back(mk({b[1:0], unmapped[k]}, 8'h00, $sformatf("unmapped_b%0d_%02h", b, unmapped[k])));
        end

        reset = 1'b1;
        addr  = 10'h01C;
        @(posedge clk);
        #1;
        check("reset_first_edge", 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold", 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", 8'h61);

        foreach (vecs[i]) apply(vecs[i].a, vecs[i].exp, vecs[i].name);

        // back-to-back: data must hold until the next edge, then follow with no bubble
        apply(10'h01C, 8'h61, "b2b_a");
        @(negedge clk);
        addr = 10'h032;
        check("b2b_hold_a", 8'h61);
        @(posedge clk);
        #1;
        check("b2b_b", 8'h62);
        @(negedge clk);
        addr = 10'h021;
        check("b2b_hold_b", 8'h62);
        @(posedge clk);
        #1;
        check("b2b_c", 8'h63);

        // reset in mid-stream overrides lookup and leaves no residue
        @(negedge clk);
        reset = 1'b1;
        addr  = 10'h11C;
        @(posedge clk);
        #1;
        check("midreset_zero", 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_release", 8'h41);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
